// File: rtl/instr_encoder_if.sv
// Command / instruction-memory bus for instr_encoder.
//   cmd_*  : mnemonic-level command handshake (valid/ready).
//   im_*   : instruction-memory write port (we/ready).
// Modports:
//   master : command source and IM (drives cmd_*, im_ready).
//   slave  : the encoder (drives cmd_ready, im_we, im_addr, im_wdata).
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_mn;
  logic [4:0]        cmd_rs;
  logic [4:0]        cmd_rt;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_shamt;
  logic [25:0]       cmd_imm;
  logic              im_we;
  logic              im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output cmd_valid, cmd_mn, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
    input  cmd_ready,
    input  im_we, im_addr, im_wdata,
    output im_ready
  );

  modport slave (
    input  cmd_valid, cmd_mn, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
    output cmd_ready,
    output im_we, im_addr, im_wdata,
    input  im_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: sequential MIPS instruction writer.
// Accepts mnemonic-level commands, encodes each into a 32-bit MIPS word,
// buffers it in a DEPTH-entry FIFO and writes it to instruction memory at an
// auto-incrementing word address.
// Ports:
//   clk, rstn   : clock (rising edge), asynchronous active-low reset
//   start       : one-cycle pulse; loads base_addr, flushes FIFO, clears stats
//   base_addr   : start word address, sampled on start
//   bus         : instr_encoder_if.slave (command handshake + IM write port)
//   wr_cnt      : completed IM writes since reset/start (wraps at 16 bits)
//   err         : sticky error flag
//   err_cnt     : dropped commands, saturating at 255
// Build option: define INSTR_ENC_CHECK_EN to drop commands carrying nonzero
// fields that the encoding would otherwise silently mask.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic [15:0]       wr_cnt,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,  MN_ADDU = 5'd1,  MN_SUB  = 5'd2,  MN_SUBU = 5'd3,
    MN_AND  = 5'd4,  MN_OR   = 5'd5,  MN_SLT  = 5'd6,  MN_SLTU = 5'd7,
    MN_SLL  = 5'd8,  MN_SRL  = 5'd9,  MN_SRA  = 5'd10, MN_JR   = 5'd11,
    MN_JALR = 5'd12, MN_ADDI = 5'd13, MN_ORI  = 5'd14, MN_SLTI = 5'd15,
    MN_SLTIU = 5'd16, MN_LUI = 5'd17, MN_LW   = 5'd18, MN_SW   = 5'd19,
    MN_BEQ  = 5'd20, MN_BNE  = 5'd21, MN_J    = 5'd22, MN_JAL  = 5'd23
  } mn_e;

  typedef enum logic [1:0] {
    K_R = 2'd0,
    K_I = 2'd1,
    K_J = 2'd2
  } kind_e;

  // ---------------------------------------------------------------- encode
  kind_e       kind;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_shift;
  logic        is_lui;
  logic        illegal;
  logic        field_err;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_sh;
  logic [31:0] enc_word;

  always_comb begin
    kind     = K_R;
    op       = '0;
    funct    = '0;
    is_shift = 1'b0;
    is_lui   = 1'b0;
    illegal  = 1'b0;
    f_rt     = bus.cmd_rt;
    f_rd     = bus.cmd_rd;
    case (mn_e'(bus.cmd_mn))
      MN_ADD:   funct = 6'h20;
      MN_ADDU:  funct = 6'h21;
      MN_SUB:   funct = 6'h22;
      MN_SUBU:  funct = 6'h23;
      MN_AND:   funct = 6'h24;
      MN_OR:    funct = 6'h25;
      MN_SLT:   funct = 6'h2A;
      MN_SLTU:  funct = 6'h2B;
      MN_SLL:   begin funct = 6'h00; is_shift = 1'b1; end
      MN_SRL:   begin funct = 6'h02; is_shift = 1'b1; end
      MN_SRA:   begin funct = 6'h03; is_shift = 1'b1; end
      MN_JR:    begin funct = 6'h08; f_rt = '0; f_rd = '0; end
      MN_JALR:  begin funct = 6'h09; f_rt = '0; end
      MN_ADDI:  begin kind = K_I; op = 6'h08; end
      MN_ORI:   begin kind = K_I; op = 6'h0D; end
      MN_SLTI:  begin kind = K_I; op = 6'h0A; end
      MN_SLTIU: begin kind = K_I; op = 6'h0B; end
      MN_LUI:   begin kind = K_I; op = 6'h0F; is_lui = 1'b1; end
      MN_LW:    begin kind = K_I; op = 6'h23; end
      MN_SW:    begin kind = K_I; op = 6'h2B; end
      MN_BEQ:   begin kind = K_I; op = 6'h04; end
      MN_BNE:   begin kind = K_I; op = 6'h05; end
      MN_J:     begin kind = K_J; op = 6'h02; end
      MN_JAL:   begin kind = K_J; op = 6'h03; end
      default:  illegal = 1'b1;
    endcase

    // Shift amount only survives on shifts; shifts and lui carry no rs.
    f_sh = is_shift ? bus.cmd_shamt : '0;
    f_rs = (is_shift || is_lui) ? '0 : bus.cmd_rs;

    case (kind)
      K_I:     enc_word = {op, f_rs, f_rt, bus.cmd_imm[15:0]};
      K_J:     enc_word = {op, bus.cmd_imm};
      default: enc_word = {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  always_comb begin
    field_err = 1'b0;
    if (kind == K_R) begin
      if (!is_shift && (bus.cmd_shamt != '0)) field_err = 1'b1;
      if (is_shift && (bus.cmd_rs != '0))     field_err = 1'b1;
      if (bus.cmd_imm != '0)                  field_err = 1'b1;
    end
    if (kind == K_I) begin
      if (bus.cmd_imm[25:16] != '0)           field_err = 1'b1;
      if (is_lui && (bus.cmd_rs != '0))       field_err = 1'b1;
    end
  end
`else
  assign field_err = 1'b0;
`endif

  // ------------------------------------------------------------------ FIFO
  logic [31:0]      mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic             drop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign bus.cmd_ready = ~full & ~start;
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign drop   = accept & (illegal | field_err);
  assign push   = accept & ~illegal & ~field_err;
  // start discards any write presented in its cycle.
  assign pop    = bus.im_we & bus.im_ready & ~start;

  assign bus.im_we    = ~empty;
  assign bus.im_wdata = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= enc_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bus.im_addr <= '0;
      wr_cnt      <= '0;
      err         <= 1'b0;
      err_cnt     <= '0;
    end else if (start) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bus.im_addr <= base_addr;
      wr_cnt      <= '0;
      err         <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        bus.im_addr <= bus.im_addr + 1'b1;
        wr_cnt      <= wr_cnt + 1'b1;
      end
      if (drop) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [9:0]  base_addr;
  logic [15:0] wr_cnt;
  logic        err;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

  instr_encoder_if #(.ADDR_W(10)) bus_if ();

  instr_encoder #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus_if.slave),
    .wr_cnt    (wr_cnt),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input string tag, input logic [4:0] mn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [25:0] imm);
    bit done = 1'b0;
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_mn    = mn;
    bus_if.cmd_rs    = rs;
    bus_if.cmd_rt    = rt;
    bus_if.cmd_rd    = rd;
    bus_if.cmd_shamt = sh;
    bus_if.cmd_imm   = imm;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus_if.cmd_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    #1 bus_if.cmd_valid = 1'b0;
  endtask

  // Checks the head write at the next falling edge, then lets IM take it.
  task automatic expect_write(input string tag, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    chk({tag, "_we"},   32'(bus_if.im_we), 32'd1);
    chk({tag, "_addr"}, 32'(bus_if.im_addr), 32'(a));
    chk({tag, "_data"}, bus_if.im_wdata, d);
    bus_if.im_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.im_ready = 1'b0;
  endtask

  logic [31:0] exp_words [4];

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    base_addr = '0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_mn = '0;
    bus_if.cmd_rs = '0;
    bus_if.cmd_rt = '0;
    bus_if.cmd_rd = '0;
    bus_if.cmd_shamt = '0;
    bus_if.cmd_imm = '0;
    bus_if.im_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_im_we",    32'(bus_if.im_we), 32'd0);
    chk("rst_im_addr",  32'(bus_if.im_addr), 32'd0);
    chk("rst_im_wdata", bus_if.im_wdata, 32'd0);
    chk("rst_wr_cnt",   32'(wr_cnt), 32'd0);
    chk("rst_err",      32'(err), 32'd0);
    chk("rst_err_cnt",  32'(err_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);

    // addi rt=8 rs=0 imm=5 at base 0
    do_start(10'h000);
    send("addi", 5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0005);
    expect_write("addi", 10'h000, 32'h20080005);
    chk("addi_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("addi_addr_inc", 32'(bus_if.im_addr), 32'd1);
    chk("addi_empty", 32'(bus_if.im_we), 32'd0);

    send("add", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    expect_write("add", 10'h001, 32'h00221820);
    send("sll", 5'd8, 5'd0, 5'd1, 5'd2, 5'd4, 26'h0);
    expect_write("sll", 10'h002, 32'h00011100);
    send("jal", 5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0100000);
    expect_write("jal", 10'h003, 32'h0C100000);
    send("lw", 5'd18, 5'd29, 5'd4, 5'd0, 5'd0, 26'h000FFFC);
    expect_write("lw", 10'h004, 32'h8FA4FFFC);
    chk("seq_wr_cnt", 32'(wr_cnt), 32'd5);

    // Fill FIFO with IM stalled, then drain back-to-back
    do_start(10'h010);
    exp_words[0] = 32'h344300FF;
    exp_words[1] = 32'h00853022;
    exp_words[2] = 32'h03E00008;
    exp_words[3] = 32'h1022FFFF;
    send("ori", 5'd14, 5'd2, 5'd3, 5'd0, 5'd0, 26'h00FF);
    send("sub", 5'd2, 5'd4, 5'd5, 5'd6, 5'd0, 26'h0);
    send("jr",  5'd11, 5'd31, 5'd0, 5'd0, 5'd0, 26'h0);
    send("beq", 5'd20, 5'd1, 5'd2, 5'd0, 5'd0, 26'hFFFF);
    @(negedge clk);
    chk("full_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    bus_if.im_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_we", i),   32'(bus_if.im_we), 32'd1);
      chk($sformatf("drain%0d_addr", i), 32'(bus_if.im_addr), 32'h10 + 32'(i));
      chk($sformatf("drain%0d_data", i), bus_if.im_wdata, exp_words[i]);
      @(negedge clk);
    end
    bus_if.im_ready = 1'b0;
    chk("drain_done_we", 32'(bus_if.im_we), 32'd0);
    chk("drain_wr_cnt",  32'(wr_cnt), 32'd4);
    chk("drain_ready",   32'(bus_if.cmd_ready), 32'd1);

    // Illegal mnemonic
    do_start(10'h020);
    send("illegal", 5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    @(negedge clk);
    chk("illegal_no_we",  32'(bus_if.im_we), 32'd0);
    chk("illegal_err",    32'(err), 32'd1);
    chk("illegal_errcnt", 32'(err_cnt), 32'd1);
    send("addu", 5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    expect_write("addu", 10'h020, 32'h00221821);
    chk("illegal_err_sticky", 32'(err), 32'd1);

    // Address wrap at 0x3FF; start clears error state
    do_start(10'h3FF);
    chk("start_clr_err",    32'(err), 32'd0);
    chk("start_clr_errcnt", 32'(err_cnt), 32'd0);
    send("slt", 5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    send("lui", 5'd17, 5'd0, 5'd7, 5'd0, 5'd0, 26'h1234);
    expect_write("wrap0", 10'h3FF, 32'h0022182A);
    expect_write("wrap1", 10'h000, 32'h3C071234);
    chk("wrap_wr_cnt", 32'(wr_cnt), 32'd2);

    // add with stray shamt
    do_start(10'h040);
    send("add_sh", 5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 26'h0);
`ifdef INSTR_ENC_CHECK_EN
    @(negedge clk);
    chk("add_sh_dropped", 32'(bus_if.im_we), 32'd0);
    chk("add_sh_errcnt",  32'(err_cnt), 32'd1);
`else
    expect_write("add_sh", 10'h040, 32'h00221820);
    chk("add_sh_no_err", 32'(err), 32'd0);
`endif

    // start wins over a simultaneous pop
    do_start(10'h060);
    send("prio", 5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0005);
    @(negedge clk);
    bus_if.im_ready = 1'b1;
    start = 1'b1;
    base_addr = 10'h070;
    #1 chk("start_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    bus_if.im_ready = 1'b0;
    chk("prio_we",     32'(bus_if.im_we), 32'd0);
    chk("prio_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("prio_addr",   32'(bus_if.im_addr), 32'h070);

    // Asynchronous reset mid-stream
    do_start(10'h055);
    send("mid0", 5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    expect_write("mid0", 10'h055, 32'h00221825);
    send("mid1", 5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    @(negedge clk);
    chk("mid_pending_we", 32'(bus_if.im_we), 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_we",     32'(bus_if.im_we), 32'd0);
    chk("arst_addr",   32'(bus_if.im_addr), 32'd0);
    chk("arst_wdata",  bus_if.im_wdata, 32'd0);
    chk("arst_wr_cnt", 32'(wr_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("arst_ready", 32'(bus_if.cmd_ready), 32'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction writer: accepts mnemonic-level commands over a valid/ready handshake, encodes each into a 32-bit instruction word, buffers it in a small FIFO and writes it into instruction memory at an auto-incrementing word address. It is the producer side of the opcode/funct decode performed in the core, and loads test programs into IM before the single-cycle CPU is released from reset.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `ADDR_W`, 10: IM word-address width.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse; loads address, flushes FIFO.
- `base_addr` in ADDR_W: start word address, sampled on `start`.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_mn` in 5: mnemonic ID.
- `cmd_rs`, `cmd_rt`, `cmd_rd`, `cmd_shamt` in 5 each: register and shift fields.
- `cmd_imm` in 26: imm16 in [15:0] for I-type; target in [25:0] for J-type.
- `im_we` out 1: write request.
- `im_ready` in 1: IM accepts the write when `im_we & im_ready`.
- `im_addr` out ADDR_W: write word address.
- `im_wdata` out 32: encoded instruction.
- `wr_cnt` out 16: completed IM writes since reset/`start`.
- `err` out 1: sticky error flag.
- `err_cnt` out 8: dropped commands, saturating at 255.

## Operation
- Mnemonic IDs → fields (op / funct, hex):
  - R-type, op 00: 0 add/20, 1 addu/21, 2 sub/22, 3 subu/23, 4 and/24, 5 or/25, 6 slt/2A, 7 sltu/2B, 8 sll/00, 9 srl/02, 10 sra/03, 11 jr/08, 12 jalr/09.
  - I-type: 13 addi/08, 14 ori/0D, 15 slti/0A, 16 sltiu/0B, 17 lui/0F, 18 lw/23, 19 sw/2B, 20 beq/04, 21 bne/05.
  - J-type: 22 j/02, 23 jal/03.
- R-type word = {op, rs, rt, rd, shamt, funct}. Field zeroing: shamt=0 for non-shifts; rs=0 for sll/srl/sra; rt=rd=shamt=0 for jr; rt=shamt=0 for jalr.
- I-type word = {op, rs, rt, imm[15:0]}; rs=0 for lui.
- J-type word = {op, imm[25:0]}.
- IDs 24–31 are illegal: command is accepted, not written; `err` set, `err_cnt` incremented.
- FIFO: encoded word pushed on an accepted legal command; head popped on `im_we & im_ready`.
- `cmd_ready = ~full & ~start`; no bypass when full, even with a simultaneous pop.
- `im_we = ~empty`; `im_wdata` = head entry, 0 when empty.
- `im_addr` increments by 1 per completed write and wraps from 2^ADDR_W−1 to 0; `wr_cnt` increments likewise and wraps at 16 bits.
- `start`: loads `im_addr` ← `base_addr`, clears FIFO, `wr_cnt`, `err` and `err_cnt`. Start has priority over any push or pop in the same cycle; an IM write presented in that cycle is discarded.

## Timing
- Reset values: `cmd_ready`=1 once `rstn` is high; `im_we`=0, `im_addr`=0, `im_wdata`=0, `wr_cnt`=0, `err`=0, `err_cnt`=0.
- Command accepted at edge T → `im_we`=1 with its word from cycle T+1.
- With `im_ready` held high, sustained throughput is 1 word/cycle.
- Reset asserted mid-stream empties the FIFO immediately, and all outputs return to their reset values asynchronously.
- Errors update on the edge that accepts the illegal command.

## Configuration
- `INSTR_ENC_CHECK_EN` defined:
  - Any nonzero field that the encoding zeroes or ignores is an error: drop the command, set `err`, increment `err_cnt`.
  - Covered cases: shamt on non-shift, rs on shift/lui, imm[25:16] on I-type, any imm on R-type.
- Not defined: such fields are silently masked and the command is written.

## Test plan
- addi rt=8 rs=0 imm=5, base 0 → `im_addr`=0, `im_wdata`=0x20080005, `wr_cnt`=1.
- add rs=1 rt=2 rd=3 → 0x00221820; sll rt=1 rd=2 shamt=4 → 0x00011100; jal imm=0x100000 → 0x0C100000; lw rs=29 rt=4 imm=0xFFFC → 0x8FA4FFFC.
- `im_ready`=0 with DEPTH=4: after the 4th accept `cmd_ready`=0; releasing `im_ready` gives 4 back-to-back writes at base..base+3 in command order.
- `cmd_mn`=25 → no IM write, `err`=1, `err_cnt`=1; a following legal command is still written.
- base=0x3FF (ADDR_W=10), two commands → writes at 0x3FF then 0x000.
- With `INSTR_ENC_CHECK_EN`: add with shamt=3 → dropped, `err_cnt`=1. Without it: add with shamt=3 → 0x00221820 written.
